// File: rtl/load_store_unit_if.sv
// Bus bundle for load_store_unit: execute-stage request, data-memory port and load writeback.
// The LSU connects through the slave modport; the environment drives the master side.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [4:0]  rd_addr;

  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rdata;

  logic        wb_valid;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_data;
  logic        done;
  logic        misalign_err;

  modport slave (
    input  req_valid, mem_read, mem_write, mem_size, mem_unsigned, addr, wdata, rd_addr,
    input  dmem_req_ready, dmem_rsp_valid, dmem_rdata,
    output req_ready, dmem_req_valid, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
    output wb_valid, wb_rd_addr, wb_data, done, misalign_err
  );

  modport master (
    output req_valid, mem_read, mem_write, mem_size, mem_unsigned, addr, wdata, rd_addr,
    output dmem_req_ready, dmem_rsp_valid, dmem_rdata,
    input  req_ready, dmem_req_valid, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
    input  wb_valid, wb_rd_addr, wb_data, done, misalign_err
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit with byte/half/word lane steering and load extension.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned and reserved-size accesses with misalign_err.
module load_store_unit (
  input logic               clk,
  input logic               rst,
  load_store_unit_if.slave  io_lsu
);

  typedef enum logic [1:0] {StIdle, StReq, StWaitRsp, StFin} state_e;

  state_e      r_state, w_state_d;
  logic [31:0] r_addr, r_wdata, r_ldata;
  logic [1:0]  r_size;
  logic [4:0]  r_rd;
  logic        r_unsigned, r_is_store, r_is_load, r_misalign;

  logic        w_accept, w_misalign_in, w_in_req, w_fin;
  logic [1:0]  w_off;
  logic [3:0]  w_strb;
  logic [31:0] w_wdata, w_shift, w_ldata;

  assign io_lsu.req_ready = (r_state == StIdle);
  assign w_accept         = io_lsu.req_valid & io_lsu.req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign_in = (io_lsu.mem_read | io_lsu.mem_write) &
                         (((io_lsu.mem_size == 2'd1) & io_lsu.addr[0]) |
                          ((io_lsu.mem_size == 2'd2) & (io_lsu.addr[1:0] != 2'b00)) |
                          (io_lsu.mem_size == 2'd3));
`else
  assign w_misalign_in = 1'b0;
`endif

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (w_misalign_in || !(io_lsu.mem_read || io_lsu.mem_write)) w_state_d = StFin;
          else                                                        w_state_d = StReq;
        end
      end
      StReq:     if (io_lsu.dmem_req_ready) w_state_d = r_is_store ? StFin : StWaitRsp;
      StWaitRsp: if (io_lsu.dmem_rsp_valid) w_state_d = StFin;
      StFin:     w_state_d = StIdle;
      default:   w_state_d = StIdle;
    endcase
  end

  // Halves force lane alignment; word and reserved size always start at lane 0.
  always_comb begin
    w_off   = 2'b00;
    w_strb  = 4'b1111;
    w_wdata = r_wdata;
    case (r_size)
      2'd0: begin
        w_off   = r_addr[1:0];
        w_strb  = 4'b0001 << r_addr[1:0];
        w_wdata = {4{r_wdata[7:0]}};
      end
      2'd1: begin
        w_off   = {r_addr[1], 1'b0};
        w_strb  = 4'b0011 << {r_addr[1], 1'b0};
        w_wdata = {2{r_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_shift = io_lsu.dmem_rdata >> {w_off, 3'b000};

  always_comb begin
    w_ldata = w_shift;
    case (r_size)
      2'd0:    w_ldata = {{24{w_shift[7] & ~r_unsigned}}, w_shift[7:0]};
      2'd1:    w_ldata = {{16{w_shift[15] & ~r_unsigned}}, w_shift[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_ldata    <= '0;
      r_size     <= '0;
      r_rd       <= '0;
      r_unsigned <= 1'b0;
      r_is_store <= 1'b0;
      r_is_load  <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_addr     <= io_lsu.addr;
        r_wdata    <= io_lsu.wdata;
        r_size     <= io_lsu.mem_size;
        r_rd       <= io_lsu.rd_addr;
        r_unsigned <= io_lsu.mem_unsigned;
        r_is_store <= io_lsu.mem_write;
        r_is_load  <= io_lsu.mem_read & ~io_lsu.mem_write;
        r_misalign <= w_misalign_in;
      end
      if ((r_state == StWaitRsp) && io_lsu.dmem_rsp_valid) r_ldata <= w_ldata;
    end
  end

  assign w_in_req = (r_state == StReq);
  assign w_fin    = (r_state == StFin);

  assign io_lsu.dmem_req_valid = w_in_req;
  assign io_lsu.dmem_we        = w_in_req & r_is_store;
  assign io_lsu.dmem_addr      = w_in_req ? {r_addr[31:2], 2'b00} : 32'd0;
  assign io_lsu.dmem_wstrb     = (w_in_req & r_is_store) ? w_strb : 4'd0;
  assign io_lsu.dmem_wdata     = (w_in_req & r_is_store) ? w_wdata : 32'd0;

  assign io_lsu.done       = w_fin & ~r_misalign;
  assign io_lsu.wb_valid   = w_fin & r_is_load & ~r_misalign;
  assign io_lsu.wb_rd_addr = r_rd;
  assign io_lsu.wb_data    = r_ldata;

`ifdef LSU_MISALIGN_TRAP_EN
  assign io_lsu.misalign_err = w_fin & r_misalign;
`else
  assign io_lsu.misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit; inputs driven and outputs sampled on negedge.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit dut (
    .clk    (clk),
    .rst    (rst),
    .io_lsu (bus)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one request for a single cycle; returns at the +1 sample point.
  task automatic issue(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rda);
    bus.req_valid    = 1'b1;
    bus.mem_read     = rd;
    bus.mem_write    = wr;
    bus.mem_size     = sz;
    bus.mem_unsigned = uns;
    bus.addr         = a;
    bus.wdata        = wd;
    bus.rd_addr      = rda;
    tick();
    bus.req_valid    = 1'b0;
  endtask

  initial begin
    bus.req_valid      = 1'b0;
    bus.mem_read       = 1'b0;
    bus.mem_write      = 1'b0;
    bus.mem_size       = 2'd0;
    bus.mem_unsigned   = 1'b0;
    bus.addr           = 32'd0;
    bus.wdata          = 32'd0;
    bus.rd_addr        = 5'd0;
    bus.dmem_req_ready = 1'b0;
    bus.dmem_rsp_valid = 1'b0;
    bus.dmem_rdata     = 32'd0;
    rst = 1'b1;
    tick();
    tick();
    check("rst_dmem_req_valid", {31'd0, bus.dmem_req_valid}, 32'd0);
    check("rst_done",           {31'd0, bus.done},           32'd0);
    check("rst_wb_valid",       {31'd0, bus.wb_valid},       32'd0);
    check("rst_wstrb",          {28'd0, bus.dmem_wstrb},     32'd0);
    check("rst_misalign",       {31'd0, bus.misalign_err},   32'd0);
    rst = 1'b0;
    tick();
    check("rst_req_ready",      {31'd0, bus.req_ready},      32'd1);

    // Store byte at offset 3, memory ready immediately
    bus.dmem_req_ready = 1'b1;
    issue(1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_1003, 32'h0000_00AB, 5'd0);
    check("sb_req_valid", {31'd0, bus.dmem_req_valid}, 32'd1);
    check("sb_addr",      bus.dmem_addr,               32'h0000_1000);
    check("sb_wstrb",     {28'd0, bus.dmem_wstrb},     32'h8);
    check("sb_wdata",     bus.dmem_wdata,              32'hABAB_ABAB);
    check("sb_we",        {31'd0, bus.dmem_we},        32'd1);
    check("sb_done_p1",   {31'd0, bus.done},           32'd0);
    tick();
    check("sb_done_p2",   {31'd0, bus.done},           32'd1);
    check("sb_wb_valid",  {31'd0, bus.wb_valid},       32'd0);
    check("sb_fin_ready", {31'd0, bus.req_ready},      32'd0);
    tick();
    check("sb_done_p3",   {31'd0, bus.done},           32'd0);
    check("sb_idle_rdy",  {31'd0, bus.req_ready},      32'd1);

    // Signed byte load; response held high so it is also presented during REQ
    bus.dmem_rsp_valid = 1'b1;
    bus.dmem_rdata     = 32'h0000_F200;
    issue(1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_2001, 32'd0, 5'd7);
    check("lb_addr",     bus.dmem_addr,               32'h0000_2000);
    check("lb_we",       {31'd0, bus.dmem_we},        32'd0);
    check("lb_wstrb",    {28'd0, bus.dmem_wstrb},     32'd0);
    tick();
    check("lb_wb_p2",    {31'd0, bus.wb_valid},       32'd0);
    tick();
    check("lb_wb_p3",    {31'd0, bus.wb_valid},       32'd1);
    check("lb_data",     bus.wb_data,                 32'hFFFF_FFF2);
    check("lb_rd",       {27'd0, bus.wb_rd_addr},     32'd7);
    check("lb_done",     {31'd0, bus.done},           32'd1);
    tick();

    // Same access, unsigned
    issue(1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_2001, 32'd0, 5'd9);
    tick();
    tick();
    check("lbu_wb",      {31'd0, bus.wb_valid},       32'd1);
    check("lbu_data",    bus.wb_data,                 32'h0000_00F2);
    tick();

    // Half load with memory stalling 4 cycles in REQ
    bus.dmem_req_ready = 1'b0;
    bus.dmem_rdata     = 32'h8001_0000;
    issue(1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_2002, 32'd0, 5'd3);
    for (int i = 1; i <= 5; i++) begin
      check("lh_stall_valid", {31'd0, bus.dmem_req_valid}, 32'd1);
      check("lh_stall_addr",  bus.dmem_addr,               32'h0000_2000);
      check("lh_stall_wb",    {31'd0, bus.wb_valid},       32'd0);
      if (i == 5) bus.dmem_req_ready = 1'b1;
      tick();
    end
    check("lh_wb_p6",    {31'd0, bus.wb_valid},       32'd0);
    tick();
    check("lh_wb_p7",    {31'd0, bus.wb_valid},       32'd1);
    check("lh_data",     bus.wb_data,                 32'hFFFF_8001);
    tick();

    // Read and write both set behaves as a store
    bus.dmem_rsp_valid = 1'b0;
    issue(1'b1, 1'b1, 2'd1, 1'b0, 32'h0000_1002, 32'h5A5A_1234, 5'd1);
    check("sh_we",       {31'd0, bus.dmem_we},        32'd1);
    check("sh_wstrb",    {28'd0, bus.dmem_wstrb},     32'hC);
    check("sh_wdata",    bus.dmem_wdata,              32'h1234_1234);
    tick();
    check("sh_done",     {31'd0, bus.done},           32'd1);
    check("sh_wb",       {31'd0, bus.wb_valid},       32'd0);
    tick();

    // No-op request finishes without touching memory
    issue(1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_5000, 32'd0, 5'd4);
    check("nop_done",    {31'd0, bus.done},           32'd1);
    check("nop_dmem",    {31'd0, bus.dmem_req_valid}, 32'd0);
    check("nop_wb",      {31'd0, bus.wb_valid},       32'd0);
    tick();

    // Misaligned word load to x0
    bus.dmem_rsp_valid = 1'b1;
    bus.dmem_rdata     = 32'h1234_5678;
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_3002, 32'd0, 5'd0);
`ifdef LSU_MISALIGN_TRAP_EN
    check("lw_mis_err",  {31'd0, bus.misalign_err},   32'd1);
    check("lw_mis_dmem", {31'd0, bus.dmem_req_valid}, 32'd0);
    check("lw_mis_done", {31'd0, bus.done},           32'd0);
    tick();
    check("lw_mis_end",  {31'd0, bus.misalign_err},   32'd0);
    check("lw_mis_wb",   {31'd0, bus.wb_valid},       32'd0);
`else
    check("lw_addr",     bus.dmem_addr,               32'h0000_3000);
    check("lw_mis_err",  {31'd0, bus.misalign_err},   32'd0);
    tick();
    tick();
    check("lw_wb",       {31'd0, bus.wb_valid},       32'd1);
    check("lw_data",     bus.wb_data,                 32'h1234_5678);
    check("lw_rd0",      {27'd0, bus.wb_rd_addr},     32'd0);
`endif
    tick();

    // Reset while waiting for a load response
    bus.dmem_rsp_valid = 1'b0;
    bus.dmem_rdata     = 32'hFFFF_FFFF;
    issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_6000, 32'd0, 5'd3);
    tick();
    check("rw_in_wait",  {31'd0, bus.dmem_req_valid}, 32'd0);
    rst = 1'b1;
    #1;
    check("rw_async_done", {31'd0, bus.done},         32'd0);
    check("rw_async_wb",   {31'd0, bus.wb_valid},     32'd0);
    tick();
    rst = 1'b0;
    bus.dmem_rsp_valid = 1'b1;
    tick();
    check("rw_wb",       {31'd0, bus.wb_valid},       32'd0);
    check("rw_done",     {31'd0, bus.done},           32'd0);
    check("rw_ready",    {31'd0, bus.req_ready},      32'd1);
    check("rw_dmem",     {31'd0, bus.dmem_req_valid}, 32'd0);
    check("rw_wstrb",    {28'd0, bus.dmem_wstrb},     32'd0);
    check("rw_wb_data",  bus.wb_data,                 32'd0);
    tick();
    check("rw_wb_late",  {31'd0, bus.wb_valid},       32'd0);
    bus.dmem_rsp_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
